// File: rtl/bus_timer_responder.sv
// Memory-mapped machine timer: 64-bit prescaled MTIME, 64-bit compare and a level IRQ.
// Reads are registered; an MTIME_HI read returns the half captured by the last MTIME_LO read.
module bus_timer_responder #(
   parameter logic [31:0] BASE_ADDR = 32'hFF20_0500,
   parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        DwReadEnable,
   input  logic        DwWriteEnable,
   input  logic [3:0]  DwByteEnable,
   input  logic [31:0] DwAddress,
   input  logic [31:0] DwWriteData,
   output logic [31:0] DwReadData,
   output logic        oHit,
   output logic        oFault,
   output logic        oTimerIRQ
);

   typedef enum logic [2:0] {
      R_MTIME_LO   = 3'd0,
      R_MTIME_HI   = 3'd1,
      R_CMP_LO     = 3'd2,
      R_CMP_HI     = 3'd3,
      R_CTRL       = 3'd4,
      R_STATUS     = 3'd5,
      R_PRESCALE   = 3'd6,
      R_UNMAPPED   = 3'd7
   } reg_e;

   logic [63:0] mtime;
   logic [63:0] cmp;
   logic [31:0] shadow_hi;
   logic [15:0] pcnt;
   logic [15:0] prescale;
   logic        en;
   logic        ie;
   logic        pending;

   logic        in_win;
   logic        rd;
   logic        wr;
   reg_e        sel;
   logic [31:0] cur_val;
   logic [31:0] rd_val;
   logic [31:0] merged;
   logic        tick;
   logic        addr_unused;

   assign addr_unused = ^DwAddress[1:0];

   always_comb begin
      in_win = (DwAddress[31:5] == BASE_ADDR[31:5]);
      rd     = DwReadEnable & in_win;
      wr     = DwWriteEnable & in_win;
      sel    = reg_e'(DwAddress[4:2]);
      tick   = en && (pcnt == prescale);
   end

   // cur_val is the live register used for lane merging; rd_val is what the bus sees
   always_comb begin
      cur_val = '0;
      rd_val  = '0;
      case (sel)
         R_MTIME_LO: begin cur_val = mtime[31:0];  rd_val = mtime[31:0]; end
         R_MTIME_HI: begin cur_val = mtime[63:32]; rd_val = shadow_hi;   end
         R_CMP_LO:   begin cur_val = cmp[31:0];    rd_val = cmp[31:0];   end
         R_CMP_HI:   begin cur_val = cmp[63:32];   rd_val = cmp[63:32];  end
         R_CTRL:     begin cur_val = {30'd0, ie, en}; rd_val = {30'd0, ie, en}; end
         R_STATUS:   begin cur_val = '0;           rd_val = {31'd0, pending}; end
         R_PRESCALE: begin cur_val = {16'd0, prescale}; rd_val = {16'd0, prescale}; end
         R_UNMAPPED: begin cur_val = '0;           rd_val = '0;          end
      endcase
   end

   always_comb begin
      merged = cur_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (DwByteEnable[i]) merged[8*i +: 8] = DwWriteData[8*i +: 8];
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         mtime      <= '0;
         cmp        <= CMP_RESET;
         shadow_hi  <= '0;
         pcnt       <= '0;
         prescale   <= '0;
         en         <= 1'b0;
         ie         <= 1'b0;
         pending    <= 1'b0;
         DwReadData <= '0;
         oHit       <= 1'b0;
         oFault     <= 1'b0;
         oTimerIRQ  <= 1'b0;
      end else begin
         oHit      <= rd | wr;
         oFault    <= (rd | wr) && (sel == R_UNMAPPED);
         pending   <= (mtime >= cmp);
         oTimerIRQ <= pending & ie;

         if (DwReadEnable) DwReadData <= in_win ? rd_val : '0;
         if (rd && (sel == R_MTIME_LO)) shadow_hi <= mtime[63:32];

         if (en) pcnt <= tick ? '0 : pcnt + 16'd1;
         if (tick) mtime <= mtime + 64'd1;

         // Later assignments override the count update: a write replaces the
         // un-incremented value, and a PRESCALE write restarts the divider.
         if (wr) begin
            case (sel)
               R_MTIME_LO: mtime <= {mtime[63:32], merged};
               R_MTIME_HI: mtime <= {merged, mtime[31:0]};
               R_CMP_LO:   cmp[31:0]  <= merged;
               R_CMP_HI:   cmp[63:32] <= merged;
               R_CTRL: begin
                  en <= merged[0];
                  ie <= merged[1];
               end
               R_PRESCALE: begin
                  prescale <= merged[15:0];
                  pcnt     <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
